// File: rtl/oh_xor_accum.sv
`default_nettype none
// ============================================================================
//  Module      : oh_xor_accum
//  Description : Streaming XOR checksum accumulator. Each DW-bit word is
//                folded to CW bits by XOR-ing its slices, then folded words
//                are XOR-accumulated across a frame ended by in_last. The
//                frame checksum, parity and saturating word count are held
//                on registered outputs behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module oh_xor_accum #(
    parameter int          DW   = 32,
    parameter int          CW   = 8,
    parameter logic [CW-1:0] INIT = '0,
    parameter int          NW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_sum,
    output logic          out_parity,
    output logic [NW-1:0] out_count
);

    localparam int          c_NSLICE = DW / CW;
    localparam logic [1:0]  c_IDLE   = 2'd0;
    localparam logic [1:0]  c_ACCUM  = 2'd1;
    localparam logic [1:0]  c_HOLD   = 2'd2;
    localparam logic [NW-1:0] c_ONE  = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] c_SAT  = {NW{1'b1}};

    logic [1:0]    r_state;
    logic [CW-1:0] r_sum;
    logic [NW-1:0] r_count;
    logic          r_mode;
    logic          r_parity;

    logic          w_accept;
    logic          w_first;
    logic [CW-1:0] w_fold;
    logic [CW-1:0] w_sum_nxt;
    logic          w_mode_nxt;

    // Handshake flags are pure decodes of the registered state.
    assign in_ready  = (r_state != c_HOLD);
    assign out_valid = (r_state == c_HOLD);
    assign w_accept  = in_valid & in_ready;
    assign w_first   = (r_state == c_IDLE);

    // Fold the input word into one CW-bit lane.
    always_comb begin
        w_fold = '0;
        for (int k = 0; k < c_NSLICE; k++) begin
            w_fold = w_fold ^ in_data[k*CW +: CW];
        end
    end

    // Candidate next checksum and mode; the first word of a frame seeds from INIT.
    always_comb begin
        w_sum_nxt  = (w_first ? INIT : r_sum) ^ w_fold;
        w_mode_nxt = w_first ? in_mode : r_mode;
    end

    // Frame state machine and result registers; only accepted words are sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_sum    <= '0;
            r_count  <= '0;
            r_mode   <= 1'b0;
            r_parity <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_ACCUM: begin
                    if (w_accept) begin
                        r_sum    <= w_sum_nxt;
                        r_mode   <= w_mode_nxt;
                        r_parity <= (^w_sum_nxt) ^ w_mode_nxt;
                        if (w_first) begin
                            r_count <= c_ONE;
                        end else if (r_count != c_SAT) begin
                            r_count <= r_count + c_ONE;
                        end
                        r_state <= in_last ? c_HOLD : c_ACCUM;
                    end
                end
                c_HOLD: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign out_sum    = r_sum;
    assign out_parity = r_parity;
    assign out_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_oh_xor_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oh_xor_accum
//  Description : Directed self-checking bench for oh_xor_accum. A default
//                instance (NW=16) covers framing, backpressure, gaps and
//                reset; a second instance (NW=4) covers count saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oh_xor_accum;

    logic        clk = 1'b0;
    logic        r_reset;
    logic        r_in_valid;
    logic [31:0] r_in_data;
    logic        r_in_last;
    logic        r_in_mode;
    logic        r_out_ready;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [7:0]  w_out_sum;
    logic        w_out_parity;
    logic [15:0] w_out_count;

    logic        r_s_in_valid;
    logic [31:0] r_s_in_data;
    logic        r_s_in_last;
    logic        r_s_out_ready;
    logic        w_s_in_ready;
    logic        w_s_out_valid;
    logic [7:0]  w_s_out_sum;
    logic        w_s_out_parity;
    logic [3:0]  w_s_out_count;

    int r_checks = 0;
    int r_passes = 0;

    always #5 clk = ~clk;

    oh_xor_accum #(.DW(32), .CW(8), .INIT(8'h00), .NW(16)) u_dut (
        .clk        (clk),
        .reset      (r_reset),
        .in_valid   (r_in_valid),
        .in_ready   (w_in_ready),
        .in_data    (r_in_data),
        .in_last    (r_in_last),
        .in_mode    (r_in_mode),
        .out_valid  (w_out_valid),
        .out_ready  (r_out_ready),
        .out_sum    (w_out_sum),
        .out_parity (w_out_parity),
        .out_count  (w_out_count)
    );

    oh_xor_accum #(.DW(32), .CW(8), .INIT(8'h00), .NW(4)) u_dut_sat (
        .clk        (clk),
        .reset      (r_reset),
        .in_valid   (r_s_in_valid),
        .in_ready   (w_s_in_ready),
        .in_data    (r_s_in_data),
        .in_last    (r_s_in_last),
        .in_mode    (1'b0),
        .out_valid  (w_s_out_valid),
        .out_ready  (r_s_out_ready),
        .out_sum    (w_s_out_sum),
        .out_parity (w_s_out_parity),
        .out_count  (w_s_out_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got === exp) begin
            r_passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for exactly one edge (caller ensures in_ready is high).
    task automatic send(input logic [31:0] data, input logic last, input logic mode);
        r_in_valid = 1'b1;
        r_in_data  = data;
        r_in_last  = last;
        r_in_mode  = mode;
        tick();
        r_in_valid = 1'b0;
        r_in_data  = 32'hx;
        r_in_last  = 1'bx;
        r_in_mode  = 1'bx;
    endtask

    task automatic check_result(input string tag, input logic [7:0] sum,
                                input logic par, input logic [15:0] cnt);
        check({tag, "_valid"},  {31'd0, w_out_valid},  32'd1);
        check({tag, "_sum"},    {24'd0, w_out_sum},    {24'd0, sum});
        check({tag, "_parity"}, {31'd0, w_out_parity}, {31'd0, par});
        check({tag, "_count"},  {16'd0, w_out_count},  {16'd0, cnt});
    endtask

    // Complete the output handshake and confirm the block reopens.
    task automatic drain(input string tag);
        r_out_ready = 1'b1;
        tick();
        r_out_ready = 1'b0;
        check({tag, "_drain_valid"}, {31'd0, w_out_valid}, 32'd0);
        check({tag, "_drain_ready"}, {31'd0, w_in_ready},  32'd1);
    endtask

    initial begin
        r_reset       = 1'b1;
        r_in_valid    = 1'b0;
        r_in_data     = 32'h0;
        r_in_last     = 1'b0;
        r_in_mode     = 1'b0;
        r_out_ready   = 1'b0;
        r_s_in_valid  = 1'b0;
        r_s_in_data   = 32'h0;
        r_s_in_last   = 1'b0;
        r_s_out_ready = 1'b0;
        tick();
        tick();
        r_reset = 1'b0;

        // Reset state
        check("rst_valid",  {31'd0, w_out_valid},  32'd0);
        check("rst_ready",  {31'd0, w_in_ready},   32'd1);
        check("rst_sum",    {24'd0, w_out_sum},    32'd0);
        check("rst_parity", {31'd0, w_out_parity}, 32'd0);
        check("rst_count",  {16'd0, w_out_count},  32'd0);

        // 1: single-word frame, 0x12^0x34^0x56^0x78 = 0x08
        send(32'h12345678, 1'b1, 1'b0);
        check_result("t1", 8'h08, 1'b1, 16'd1);
        check("t1_ready_hold", {31'd0, w_in_ready}, 32'd0);
        drain("t1");

        // 2: two words, odd mode latched on first word; 0x08^0xFF = 0xF7
        send(32'h12345678, 1'b0, 1'b1);
        check("t2_mid_valid", {31'd0, w_out_valid}, 32'd0);
        send(32'h000000FF, 1'b1, 1'b0);
        check_result("t2", 8'hF7, 1'b0, 16'd2);
        drain("t2");

        // 3: backpressure with a pending word offered during HOLD
        send(32'h12345678, 1'b1, 1'b0);
        r_in_valid = 1'b1;
        r_in_data  = 32'h000000AA;
        r_in_last  = 1'b1;
        r_in_mode  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_result("t3_hold", 8'h08, 1'b1, 16'd1);
            check("t3_ready_hold", {31'd0, w_in_ready}, 32'd0);
            tick();
        end
        check_result("t3_hold_end", 8'h08, 1'b1, 16'd1);
        r_out_ready = 1'b1;
        tick();
        r_out_ready = 1'b0;
        check("t3_released_valid", {31'd0, w_out_valid}, 32'd0);
        check("t3_released_ready", {31'd0, w_in_ready},  32'd1);
        tick();
        r_in_valid = 1'b0;
        check_result("t3_pending", 8'hAA, 1'b0, 16'd1);
        drain("t3");

        // 4: gaps inside a frame
        send(32'h00000001, 1'b0, 1'b0);
        tick();
        tick();
        check("t4_gap_valid", {31'd0, w_out_valid}, 32'd0);
        send(32'h00000002, 1'b0, 1'b0);
        tick();
        send(32'h00000004, 1'b1, 1'b0);
        check_result("t4", 8'h07, 1'b1, 16'd3);
        drain("t4");

        // 5: reset mid-frame discards the partial frame
        send(32'hAAAAAAAA, 1'b0, 1'b0);
        send(32'h55555555, 1'b0, 1'b0);
        r_reset = 1'b1;
        tick();
        r_reset = 1'b0;
        check("t5_rst_valid", {31'd0, w_out_valid}, 32'd0);
        check("t5_rst_ready", {31'd0, w_in_ready},  32'd1);
        check("t5_rst_sum",   {24'd0, w_out_sum},   32'd0);
        send(32'h00000001, 1'b1, 1'b0);
        check_result("t5", 8'h01, 1'b1, 16'd1);

        // Reset while in HOLD
        r_reset = 1'b1;
        tick();
        r_reset = 1'b0;
        check("t5_hold_rst_valid", {31'd0, w_out_valid}, 32'd0);
        check("t5_hold_rst_count", {16'd0, w_out_count}, 32'd0);

        // 6: 20 words into a 4-bit counter saturate at 15
        for (int i = 0; i < 20; i++) begin
            r_s_in_valid = 1'b1;
            r_s_in_data  = 32'h01010101;
            r_s_in_last  = (i == 19);
            tick();
        end
        r_s_in_valid = 1'b0;
        check("t6_valid",  {31'd0, w_s_out_valid},  32'd1);
        check("t6_count",  {28'd0, w_s_out_count},  32'd15);
        check("t6_sum",    {24'd0, w_s_out_sum},    32'd0);
        check("t6_parity", {31'd0, w_s_out_parity}, 32'd0);
        r_s_out_ready = 1'b1;
        tick();
        r_s_out_ready = 1'b0;
        check("t6_drain_valid", {31'd0, w_s_out_valid}, 32'd0);

        $display("%0d/%0d checks passed", r_passes, r_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oh_xor_accum.md
Name: oh_xor_accum

Overview:
- Streaming XOR checksum accumulator.
- Folds each DW-bit input word into a CW-bit lane by XOR-ing its DW/CW slices, then XOR-accumulates the folded words across a frame delimited by in_last.
- Presents checksum, parity bit and word count on a registered output with valid/ready backpressure.
- Sits at stream-endpoint boundaries: packet integrity check and link self-test.

Parameters:
- DW, 32, input word width in bits; must be a multiple of CW.
- CW, 8, checksum width in bits; 1 <= CW <= DW.
- INIT, 0, CW-bit seed XOR-ed into the first word of every frame.
- NW, 16, word-count width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DW  input word.
- in_last  input  1  word is the final word of the frame.
- in_mode  input  1  parity sense: 0 = even, 1 = odd; sampled with the first word of a frame.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  CW  XOR checksum of the frame.
- out_parity  output  1  XOR-reduction of out_sum, XOR-ed with the latched mode.
- out_count  output  NW  number of words in the frame, saturating.

Behaviour:
- Accept: a word is accepted in a cycle where in_valid & in_ready.
- Fold: fold(w) is the XOR of slices w[k*CW +: CW], for k = 0 .. DW/CW-1.
- States:
  - IDLE: no frame open.
  - ACCUM: frame open, at least one word accepted.
  - HOLD: result waiting for out_ready.
- in_ready is 1 in IDLE and ACCUM, 0 in HOLD. It is a registered-state decode only, with no combinational path from out_ready.
- IDLE, word accepted:
  - sum <= INIT ^ fold(in_data), count <= 1, mode latched from in_mode.
  - If in_last, go to HOLD; else go to ACCUM.
- ACCUM, word accepted:
  - sum <= sum ^ fold(in_data).
  - count <= count + 1, saturating at all-ones (2^NW-1); no wrap.
  - If in_last, go to HOLD. in_mode is ignored in ACCUM.
- HOLD:
  - out_valid = 1; out_sum, out_parity and out_count are stable and unchanged until the handshake.
  - When out_ready = 1: go to IDLE. out_valid = 0 and in_ready = 1 from the next cycle.
- Latency: if the last word is accepted in cycle N, out_valid is high in cycle N+1. A single-word frame therefore also has 1-cycle latency.
- Throughput: at most one frame per 2 cycles; back-to-back words within a frame are accepted every cycle.
- in_valid = 0 in ACCUM holds all state; frames may have gaps.
- in_valid during HOLD: the word is not accepted, and the source must hold it per the valid/ready rule.
- out_ready while out_valid = 0 has no effect.
- Reset, including mid-frame or in HOLD, is applied on the next edge:
  - state = IDLE; sum = 0, count = 0, mode = 0.
  - out_valid = 0, in_ready = 1, out_sum = 0, out_parity = 0, out_count = 0.
  - Partial frames are discarded.
  - Reset has priority over any simultaneous accept or out handshake.
- Outputs out_sum, out_parity and out_count are driven from registers. Outside HOLD their values are don't-care but must not be X after reset.
- X-safety: in_data, in_last and in_mode are not sampled unless the word is accepted.

Test Plan (DW=32, CW=8, INIT=0, NW=16):
1. Single-word frame: 0x12345678 with last=1, mode=0.
   -> One cycle later out_valid=1, out_sum=0x08, out_parity=1, out_count=1.
2. Two-word frame, mode=1: 0x12345678, then 0x000000FF with last=1.
   -> out_sum=0xF7, out_parity=0, out_count=2.
   -> in_mode=0 driven on the second word must not change the result.
3. Backpressure: repeat test 1 with out_ready=0 for 3 cycles.
   -> out_valid and all outputs stable 3 cycles, in_ready=0 throughout.
   -> A word offered with in_valid=1 is not accepted until the cycle after out_ready=1.
4. Gaps: frame 0x01, (idle 2 cycles), 0x02, (idle 1 cycle), 0x04 with last.
   -> out_sum=0x07, out_parity=1, out_count=3.
5. Reset mid-frame: accept 0xAAAAAAAA and 0x55555555, then pulse reset for 1 cycle.
   -> out_valid=0, in_ready=1, out_sum=0.
   -> Next frame 0x00000001 with last gives out_sum=0x01, out_count=1.
6. Saturation: NW=4 build, frame of 20 words of 0x01010101 (fold 0x00).
   -> out_count=15, out_sum=0x00, out_parity=0 (mode=0).
